ram_arbiter: RTL and testbench

Sequences the shared 8-bit `bus`, plus `enable` and `rw`, of the single-port `ram` block on behalf of several requesters. It arbitrates between them and runs the RAM's two-phase protocol: address then data for writes, address then turnaround then capture for reads. It returns read data and a one-cycle completion pulse to the requester it served. It sits between the core's memory clients (fetch, load/store, debug) and `ram`, and is the only master that drives `bus` toward the RAM.

---
 rtl/ram_arb_pkg.sv | 27 ++
 rtl/ram_arb_pick.sv | 53 +++++
 rtl/tri_buf.sv | 15 +
 rtl/ram_arbiter.sv | 175 +++++++++++++++++
 tb/tb_ram_arbiter.sv | 304 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ram_arb_pkg.sv
// ram_arb_pkg: shared types and constants for the ram_arbiter slice.
//   BITW            - width of the RAM bus, addresses and data
//   ram_arb_state_t - sequencer states
//   ram_arb_idx_t   - requester index (up to 4 requesters)
//   wrap_inc        - index + 1, wrapping at the requester count
package ram_arb_pkg;

  localparam int unsigned BITW = 8;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WR_ADDR,
    S_WR_DATA,
    S_RD_ADDR,
    S_RD_WAIT,
    S_RD_CAP
  } ram_arb_state_t;

  typedef logic [1:0] ram_arb_idx_t;

  function automatic ram_arb_idx_t wrap_inc(input ram_arb_idx_t idx,
                                            input int unsigned  n);
    if (32'(idx) + 32'd1 >= n) return '0;
    return idx + 2'd1;
  endfunction

endpackage

// File: rtl/ram_arb_pick.sv
// ram_arb_pick: combinational winner selection among eligible requesters.
//   elig_i  - eligible requester mask
//   ptr_i   - round-robin start index (ignored under fixed priority)
//   win_o   - one-hot winner (all zero when nothing is eligible)
//   valid_o - at least one requester is eligible
// Macro RAM_ARB_ROUND_ROBIN_EN: defined -> search starts at ptr_i and wraps;
// undefined -> fixed priority, lowest index wins.
module ram_arb_pick
  import ram_arb_pkg::*;
#(
  parameter int unsigned NREQ = 2
) (
  input  logic [NREQ-1:0] elig_i,
  input  ram_arb_idx_t    ptr_i,
  output logic [NREQ-1:0] win_o,
  output logic            valid_o
);

  logic found;

`ifdef RAM_ARB_ROUND_ROBIN_EN
  always_comb begin
    win_o = '0;
    found = 1'b0;
    // Visit requesters in order ptr, ptr+1, ... (mod NREQ); first eligible wins.
    for (int unsigned off = 0; off < NREQ; off++) begin
      for (int unsigned i = 0; i < NREQ; i++) begin
        if (!found && elig_i[i] && (i == (32'(ptr_i) + off) % NREQ)) begin
          win_o[i] = 1'b1;
          found    = 1'b1;
        end
      end
    end
  end
`else
  logic unused_ptr;
  assign unused_ptr = ^ptr_i;

  always_comb begin
    win_o = '0;
    found = 1'b0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (!found && elig_i[i]) begin
        win_o[i] = 1'b1;
        found    = 1'b1;
      end
    end
  end
`endif

  assign valid_o = |elig_i;

endmodule

// File: rtl/tri_buf.sv
// tri_buf: plain tri-state driver.
//   d_i  - value to drive
//   oe_i - drive enable; released (high-Z) when low
//   y_io - driven net
module tri_buf #(
  parameter int unsigned WIDTH = 8
) (
  input  logic [WIDTH-1:0] d_i,
  input  logic             oe_i,
  inout  logic [WIDTH-1:0] y_io
);

  assign y_io = oe_i ? d_i : 'z;

endmodule

// File: rtl/ram_arbiter.sv
// ram_arbiter: arbitrates NREQ requesters onto the single-port RAM bus and
// runs the RAM's two-phase write (addr, data) and read (addr, turnaround,
// capture) sequences.
//   clock, reset          - rising-edge clock, synchronous active-high reset
//   req/req_rw            - per-requester request level and direction (1=write)
//   req_addr/req_wdata    - per-requester packed address / write data
//   grant                 - one-hot, high for the whole transaction
//   done                  - one-hot, one-cycle completion pulse
//   rdata                 - read data, valid with done for a read
//   ram_enable/ram_rw     - RAM control (ram.n_reset is driven from ~reset)
//   bus                   - shared bidirectional RAM bus
// Macro RAM_ARB_ROUND_ROBIN_EN selects round-robin arbitration; otherwise
// fixed priority (lowest index) with no pointer register.
module ram_arbiter
  import ram_arb_pkg::*;
#(
  parameter int unsigned NREQ = 2
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [NREQ-1:0]      req,
  input  logic [NREQ-1:0]      req_rw,
  input  logic [NREQ*BITW-1:0] req_addr,
  input  logic [NREQ*BITW-1:0] req_wdata,
  output logic [NREQ-1:0]      grant,
  output logic [NREQ-1:0]      done,
  output logic [BITW-1:0]      rdata,
  output logic                 ram_enable,
  output logic                 ram_rw,
  inout  logic [BITW-1:0]      bus
);

  ram_arb_state_t  state_q, state_d;
  logic [NREQ-1:0] grant_q, grant_d;
  logic [NREQ-1:0] done_q, done_d;
  logic [BITW-1:0] rdata_q, rdata_d;
  logic            en_q, en_d;
  logic            rw_q, rw_d;
  logic [BITW-1:0] addr_q, addr_d;
  logic [BITW-1:0] wdata_q, wdata_d;

  logic [NREQ-1:0] elig, win;
  logic            win_valid;
  ram_arb_idx_t    ptr_w;
  logic            sel_rw;
  logic [BITW-1:0] sel_addr, sel_wdata;
  logic            bus_oe;
  logic [BITW-1:0] bus_out;

  // A requester completing this cycle is not re-granted on its stale level.
  assign elig = req & ~done_q;

  ram_arb_pick #(.NREQ(NREQ)) u_pick (
    .elig_i  (elig),
    .ptr_i   (ptr_w),
    .win_o   (win),
    .valid_o (win_valid)
  );

  always_comb begin
    sel_rw    = 1'b0;
    sel_addr  = '0;
    sel_wdata = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (win[i]) begin
        sel_rw    = req_rw[i];
        sel_addr  = req_addr[i*BITW +: BITW];
        sel_wdata = req_wdata[i*BITW +: BITW];
      end
    end
  end

`ifdef RAM_ARB_ROUND_ROBIN_EN
  ram_arb_idx_t ptr_q, ptr_d, win_idx;

  always_comb begin
    win_idx = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (win[i]) win_idx = ram_arb_idx_t'(i);
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (state_q == S_IDLE && win_valid) ptr_d = wrap_inc(win_idx, NREQ);
  end

  always_ff @(posedge clock) begin
    if (reset) ptr_q <= '0;
    else       ptr_q <= ptr_d;
  end

  assign ptr_w = ptr_q;
`else
  assign ptr_w = '0;
`endif

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    done_d  = '0;
    rdata_d = rdata_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    unique case (state_q)
      S_IDLE: begin
        if (win_valid) begin
          grant_d = win;
          addr_d  = sel_addr;
          wdata_d = sel_wdata;
          state_d = sel_rw ? S_WR_ADDR : S_RD_ADDR;
        end
      end
      S_WR_ADDR: state_d = S_WR_DATA;
      S_WR_DATA: begin
        done_d  = grant_q;
        grant_d = '0;
        state_d = S_IDLE;
      end
      S_RD_ADDR: state_d = S_RD_WAIT;
      S_RD_WAIT: state_d = S_RD_CAP;
      S_RD_CAP: begin
        rdata_d = bus;
        done_d  = grant_q;
        grant_d = '0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    // RAM controls are registered, so they decode from the upcoming state.
    en_d = (state_d == S_WR_ADDR) || (state_d == S_WR_DATA) ||
           (state_d == S_RD_ADDR) || (state_d == S_RD_WAIT);
    rw_d = (state_d == S_WR_ADDR) || (state_d == S_WR_DATA);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= S_IDLE;
      grant_q <= '0;
      done_q  <= '0;
      rdata_q <= '0;
      en_q    <= 1'b0;
      rw_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      done_q  <= done_d;
      rdata_q <= rdata_d;
      en_q    <= en_d;
      rw_q    <= rw_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
    end
  end

  // Drive only during address/data phases; released in IDLE, RD_WAIT, RD_CAP.
  assign bus_oe  = (state_q == S_WR_ADDR) || (state_q == S_WR_DATA) ||
                   (state_q == S_RD_ADDR);
  assign bus_out = (state_q == S_WR_DATA) ? wdata_q : addr_q;

  tri_buf #(.WIDTH(BITW)) u_bus_buf (
    .d_i  (bus_out),
    .oe_i (bus_oe),
    .y_io (bus)
  );

  assign grant      = grant_q;
  assign done       = done_q;
  assign rdata      = rdata_q;
  assign ram_enable = en_q;
  assign ram_rw     = rw_q;

endmodule

// File: tb/tb_ram_arbiter.sv
// tb_ram_arbiter: bench for ram_arbiter with a behavioural RAM on the bus and
// a transaction-level reference model. Honours RAM_ARB_ROUND_ROBIN_EN.
module tb_ram_arbiter;

  localparam int NREQ = 2;

  logic              clock = 1'b0;
  logic              reset;
  logic [NREQ-1:0]   req, req_rw;
  logic [NREQ*8-1:0] req_addr, req_wdata;
  logic [NREQ-1:0]   grant, done;
  logic [7:0]        rdata;
  logic              ram_enable, ram_rw;
  wire  [7:0]        bus;

  int n_chk  = 0;
  int n_pass = 0;
  bit armed  = 1'b0;

  always #5 clock = ~clock;

  ram_arbiter #(.NREQ(NREQ)) dut (
    .clock      (clock),
    .reset      (reset),
    .req        (req),
    .req_rw     (req_rw),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .grant      (grant),
    .done       (done),
    .rdata      (rdata),
    .ram_enable (ram_enable),
    .ram_rw     (ram_rw),
    .bus        (bus)
  );

  // ---------------- behavioural RAM (two-phase, reset via n_reset) -----------
  logic [7:0] ram_mem [256] = '{default: 8'h00};
  logic [7:0] ram_addr_q = 8'h00, ram_out_q = 8'h00;
  logic       ram_ph_q = 1'b0, ram_drv_q = 1'b0;
  wire        n_reset = ~reset;

  assign bus = ram_drv_q ? ram_out_q : 'z;

  always @(posedge clock) begin
    if (!n_reset) begin
      ram_ph_q  <= 1'b0;
      ram_drv_q <= 1'b0;
    end else begin
      ram_drv_q <= 1'b0;
      if (ram_enable) begin
        if (!ram_ph_q) begin
          ram_addr_q <= bus;
          ram_ph_q   <= 1'b1;
        end else begin
          ram_ph_q <= 1'b0;
          if (ram_rw) ram_mem[ram_addr_q] <= bus;
          else begin
            ram_out_q <= ram_mem[ram_addr_q];
            ram_drv_q <= 1'b1;
          end
        end
      end else ram_ph_q <= 1'b0;
    end
  end

  // ---------------- reference model ----------------------------------------
  // Tracks one transaction as a cycle offset k from the grant decision:
  // write -> k=1 addr, k=2 data, k=3 done; read -> k=1 addr, k=2 turnaround,
  // k=3 RAM drives bus, k=4 done with data.
  logic [7:0]      ref_mem [256] = '{default: 8'h00};
  logic [NREQ-1:0] m_grant = '0, m_done = '0;
  logic            m_en = 1'b0, m_rw = 1'b0, m_bus_drv = 1'b0, m_cap = 1'b0, m_rd_done = 1'b0;
  logic [7:0]      m_bus = 8'h00, m_rdata = 8'h00, m_addr = 8'h00, m_wdata = 8'h00;
  bit              m_busy = 1'b0, m_wr = 1'b0;
  int              m_k = 0, m_win = 0, m_ptr = 0;

  function automatic int m_pick(input logic [NREQ-1:0] e);
    for (int off = 0; off < NREQ; off++) begin
      int idx;
      idx = (m_ptr + off) % NREQ;
      if (e[idx]) return idx;
    end
    return 0;
  endfunction

  always @(posedge clock) begin
    logic [NREQ-1:0] elig;
    if (reset) begin
      m_grant = '0; m_done = '0; m_en = 0; m_rw = 0; m_bus_drv = 0; m_cap = 0;
      m_rd_done = 0; m_rdata = 8'h00; m_busy = 0; m_ptr = 0;
    end else begin
      if (!m_busy) begin
        elig = req & ~m_done;
        if (elig != '0) begin
          m_win   = m_pick(elig);
          m_busy  = 1'b1;
          m_k     = 0;
          m_wr    = req_rw[m_win];
          m_addr  = req_addr[m_win*8 +: 8];
          m_wdata = req_wdata[m_win*8 +: 8];
`ifdef RAM_ARB_ROUND_ROBIN_EN
          m_ptr = (m_win + 1) % NREQ;
`endif
        end
      end
      m_grant = '0; m_done = '0; m_en = 0; m_rw = 0; m_bus_drv = 0; m_cap = 0; m_rd_done = 0;
      if (m_busy) begin
        m_k++;
        if (m_wr) begin
          if (m_k <= 2) begin
            m_grant[m_win] = 1'b1; m_en = 1'b1; m_rw = 1'b1; m_bus_drv = 1'b1;
            m_bus = (m_k == 1) ? m_addr : m_wdata;
          end else begin
            ref_mem[m_addr] = m_wdata;
            m_done[m_win] = 1'b1;
            m_busy = 1'b0;
          end
        end else begin
          if (m_k <= 3) m_grant[m_win] = 1'b1;
          if (m_k <= 2) m_en = 1'b1;
          if (m_k == 1) begin m_bus_drv = 1'b1; m_bus = m_addr; end
          if (m_k == 3) begin m_cap = 1'b1; m_bus_drv = 1'b1; m_bus = ref_mem[m_addr]; end
          if (m_k == 4) begin
            m_done[m_win] = 1'b1; m_rd_done = 1'b1; m_rdata = ref_mem[m_addr];
            m_busy = 1'b0;
          end
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  // ---------------- per-cycle compare against the model --------------------
  always @(negedge clock) begin
    if (armed) begin
      chk("grant", 32'(grant), 32'(m_grant));
      chk("done", 32'(done), 32'(m_done));
      chk("ram_enable", 32'(ram_enable), 32'(m_en));
      chk("ram_rw", 32'(ram_rw), 32'(m_rw));
      if (m_bus_drv) chk("bus", 32'(bus), 32'(m_bus));
      if (m_cap) begin
        chk("rdcap_bus_known", 32'(!$isunknown(bus)), 32'd1);
        chk("rdcap_arb_released", 32'(dut.bus_oe), 32'd0);
      end
      if (m_rd_done) chk("rdata", 32'(rdata), 32'(m_rdata));
    end
  end

  // ---------------- directed helpers ---------------------------------------
  task automatic set_req(input int i, input bit rw, input logic [7:0] a, input logic [7:0] d);
    req[i] = 1'b1;
    req_rw[i] = rw;
    req_addr[i*8 +: 8] = a;
    req_wdata[i*8 +: 8] = d;
  endtask

  // Called at a negedge with the arbiter idle; that cycle is cycle 0.
  task automatic run_txn(input int i, input bit rw, input logic [7:0] a, input logic [7:0] d,
                         input int exp_cyc, input logic [7:0] exp_rd,
                         input int chg_cyc, input logic [7:0] chg_addr);
    bit seen = 1'b0;
    set_req(i, rw, a, d);
    for (int c = 1; c <= 30 && !seen; c++) begin
      @(negedge clock);
      if (c == chg_cyc) req_addr[i*8 +: 8] = chg_addr;
      if (!rw && c == 3) chk("lit_rdcap_enable_low", 32'(ram_enable), 32'd0);
      if (done[i]) begin
        seen = 1'b1;
        chk("lit_done_cycle", 32'(c), 32'(exp_cyc));
        if (!rw) chk("lit_rdata", 32'(rdata), 32'(exp_rd));
        req[i] = 1'b0;
      end
    end
    if (!seen) chk("lit_done_timeout", 32'd0, 32'd1);
    @(negedge clock);
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    req   = '0;
    repeat (2) @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
  endtask

  // ---------------- stimulus ----------------------------------------------
  initial begin
    int order [4];
    int got;
    bit seen;

    reset = 1'b1; req = '0; req_rw = '0; req_addr = '0; req_wdata = '0;
    repeat (3) @(negedge clock);
    armed = 1'b1;
    chk("rst_grant", 32'(grant), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_rdata", 32'(rdata), 32'd0);
    chk("rst_ram_enable", 32'(ram_enable), 32'd0);
    chk("rst_ram_rw", 32'(ram_rw), 32'd0);
    reset = 1'b0;
    @(negedge clock);

    // Single write then read by requester 0.
    run_txn(0, 1'b1, 8'h3C, 8'hA5, 3, 8'h00, -1, 8'h00);
    run_txn(0, 1'b0, 8'h3C, 8'h00, 4, 8'hA5, -1, 8'h00);

    // Both requesters held; the done mask keeps the just-served one out of
    // the completion-cycle arbitration, so service alternates 0,1,0,1.
    pulse_reset();
    set_req(0, 1'b0, 8'h10, 8'h00);
    set_req(1, 1'b0, 8'h20, 8'h00);
    got = 0;
    for (int c = 0; c < 40 && got < 4; c++) begin
      @(negedge clock);
      if (done != '0) begin
        order[got] = done[1] ? 1 : 0;
        got++;
      end
    end
    req = '0;
    chk("alt_count", 32'(got), 32'd4);
    for (int k = 0; k < 4; k++) if (k < got) chk("alt_order", 32'(order[k]), 32'(k % 2));
    repeat (6) @(negedge clock);

    // Back-to-back: req1's write issues in req0's done cycle.
    pulse_reset();
    set_req(0, 1'b0, 8'h3C, 8'h00);
    set_req(1, 1'b1, 8'h40, 8'h77);
    seen = 1'b0;
    for (int c = 1; c <= 20 && !seen; c++) begin
      @(negedge clock);
      if (done[0]) begin
        seen = 1'b1;
        chk("b2b_done0_cycle", 32'(c), 32'd4);
        req[0] = 1'b0;
      end
    end
    if (!seen) chk("b2b_timeout", 32'd0, 32'd1);
    @(negedge clock);
    chk("b2b_grant1", 32'(grant), 32'd2);
    chk("b2b_wr_addr_bus", 32'(bus), 32'h40);
    chk("b2b_ram_rw", 32'(ram_rw), 32'd1);
    repeat (2) @(negedge clock);
    chk("b2b_done1", 32'(done), 32'd2);
    req[1] = 1'b0;
    @(negedge clock);

    // Address change during RD_WAIT must not affect the read in flight.
    run_txn(0, 1'b1, 8'h05, 8'h5A, 3, 8'h00, -1, 8'h00);
    run_txn(0, 1'b1, 8'h06, 8'h66, 3, 8'h00, -1, 8'h00);
    run_txn(0, 1'b0, 8'h05, 8'h00, 4, 8'h5A, 2, 8'h06);

    // Reset while in WR_ADDR: no write lands in the RAM.
    set_req(0, 1'b1, 8'h70, 8'h99);
    @(negedge clock);
    chk("wra_grant", 32'(grant), 32'd1);
    chk("wra_enable", 32'(ram_enable), 32'd1);
    reset = 1'b1;
    req = '0;
    @(negedge clock);
    chk("midrst_grant", 32'(grant), 32'd0);
    chk("midrst_done", 32'(done), 32'd0);
    chk("midrst_enable", 32'(ram_enable), 32'd0);
    chk("midrst_rw", 32'(ram_rw), 32'd0);
    reset = 1'b0;
    @(negedge clock);
    run_txn(0, 1'b0, 8'h70, 8'h00, 4, 8'h00, -1, 8'h00);

    // Randomised traffic against the model.
    for (int c = 0; c < 600; c++) begin
      @(negedge clock);
      if (reset) reset = 1'b0;
      else if ($urandom_range(0, 249) == 0) begin
        reset = 1'b1;
        req = '0;
      end
      if (!reset) begin
        for (int i = 0; i < NREQ; i++) begin
          if (req[i]) begin
            if (m_done[i]) begin
              if ($urandom_range(0, 1) == 0) req[i] = 1'b0;
              else set_req(i, 1'($urandom_range(0, 1)), 8'($urandom_range(0, 15)), 8'($urandom));
            end
          end else if ($urandom_range(0, 2) == 0) begin
            set_req(i, 1'($urandom_range(0, 1)), 8'($urandom_range(0, 15)), 8'($urandom));
          end
        end
      end
    end
    reset = 1'b0;
    req = '0;
    repeat (8) @(negedge clock);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
